// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared constants and sizing helpers for the sync_fifo_ctrl RAM sequencer.
// Optional Flush port is enabled by defining SYNC_FIFO_CTRL_FLUSH_EN.
package sync_fifo_ctrl_pkg;

    localparam int SKID_DEPTH    = 2;
    localparam int DEFAULT_DEPTH = 16;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    localparam int CNT_W = addr_w(DEFAULT_DEPTH) + 2;

endpackage

// File: rtl/sync_fifo_skid.sv
// Two-entry register FIFO that absorbs the RAM's registered read data.
// Entry 0 is always the head, so the head output comes straight from a flop.
module sync_fifo_skid
    import sync_fifo_ctrl_pkg::*;
#(
    parameter int DataWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] pushData_i,
    input  logic                 pop_i,
    output logic                 valid_o,
    output logic [DataWidth-1:0] head_o,
    output logic [1:0]           cnt_o
);

    logic [DataWidth-1:0] entry0_q, entry0_d;
    logic [DataWidth-1:0] entry1_q, entry1_d;
    logic [1:0]           cnt_q, cnt_d;

    // A simultaneous push and pop shifts entry 1 forward and refills behind it.
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            cnt_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        entry0_d = pushData_i;
                        cnt_d    = 2'd1;
                    end else if (cnt_q < 2'(SKID_DEPTH)) begin
                        entry1_d = pushData_i;
                        cnt_d    = cnt_q + 2'd1;
                    end
                end
                2'b01: begin
                    entry0_d = entry1_q;
                    cnt_d    = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd2) begin
                        entry0_d = entry1_q;
                        entry1_d = pushData_i;
                    end else begin
                        entry0_d = pushData_i;
                        cnt_d    = 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry0_q <= '0;
            entry1_q <= '0;
            cnt_q    <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            cnt_q    <= cnt_d;
        end
    end

    assign valid_o = (cnt_q != 2'd0);
    assign head_o  = entry0_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Valid/ready FIFO controller around a dual-port RAM with a 1-cycle registered read.
// Define SYNC_FIFO_CTRL_FLUSH_EN to add the synchronous Flush input.
module sync_fifo_ctrl
    import sync_fifo_ctrl_pkg::*;
#(
    parameter  int DataWidth = 64,
    parameter  int Deepth    = 16,
    localparam int AW        = addr_w(Deepth)
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [DataWidth-1:0] InData,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [DataWidth-1:0] OutData,
`ifdef SYNC_FIFO_CTRL_FLUSH_EN
    input  logic                 Flush,
`endif
    output logic                 RamWEnc,
    output logic [AW-1:0]        RamWAddr,
    output logic [DataWidth-1:0] RamWData,
    output logic                 RamREnc,
    output logic [AW-1:0]        RamRAddr,
    input  logic [DataWidth-1:0] RamRData,
    output logic                 Full,
    output logic                 Empty,
    output logic [AW+1:0]        Count
);

    logic [AW:0] wPtr_q, wPtr_d;
    logic [AW:0] rPtr_q, rPtr_d;
    logic        pending_q, pending_d;
    logic [AW:0] ramCnt;
    logic        ramFull;
    logic        flush;
    logic        pop;
    logic        push;
    logic        skidValid;
    logic [1:0]  skidCnt;
    logic [2:0]  skidOcc;

`ifdef SYNC_FIFO_CTRL_FLUSH_EN
    assign flush = Flush;
`else
    assign flush = 1'b0;
`endif

    assign ramCnt  = wPtr_q - rPtr_q;
    assign ramFull = (ramCnt == (AW+1)'(Deepth));

    assign InReady  = Rst && !ramFull && !flush;
    assign RamWEnc  = InValid && InReady;
    assign RamWAddr = wPtr_q[AW-1:0];
    assign RamWData = InData;

    assign OutValid = skidValid && !flush;
    assign pop      = OutValid && OutReady;
    assign push     = pending_q && !flush;

    // Only issue a read when the skid is guaranteed room once the data returns.
    assign skidOcc  = {1'b0, skidCnt} + {2'b00, pending_q};
    assign RamREnc  = Rst && !flush && (ramCnt != '0) &&
                      (skidOcc < (3'(SKID_DEPTH) + {2'b00, pop}));
    assign RamRAddr = rPtr_q[AW-1:0];

    always_comb begin
        wPtr_d    = wPtr_q + {{AW{1'b0}}, RamWEnc};
        rPtr_d    = rPtr_q + {{AW{1'b0}}, RamREnc};
        pending_d = RamREnc;
        if (flush) begin
            wPtr_d    = '0;
            rPtr_d    = '0;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wPtr_q    <= '0;
            rPtr_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            wPtr_q    <= wPtr_d;
            rPtr_q    <= rPtr_d;
            pending_q <= pending_d;
        end
    end

    sync_fifo_skid #(
        .DataWidth (DataWidth)
    ) uSkid (
        .clk_i      (Clk),
        .rst_ni     (Rst),
        .clear_i    (flush),
        .push_i     (push),
        .pushData_i (RamRData),
        .pop_i      (pop),
        .valid_o    (skidValid),
        .head_o     (OutData),
        .cnt_o      (skidCnt)
    );

    assign Count = {1'b0, ramCnt} + (AW+2)'(skidCnt) + (AW+2)'(pending_q);
    assign Empty = (Count == '0);
    assign Full  = Rst && !InReady;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl with a behavioural RAM and a queue model.
// Covers the Flush path as well when SYNC_FIFO_CTRL_FLUSH_EN is defined.
module tb_sync_fifo_ctrl;
    import sync_fifo_ctrl_pkg::*;

    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic              Clk = 1'b0;
    logic              Rst = 1'b0;
    logic              InValid = 1'b0;
    logic              OutReady = 1'b0;
    logic [DW-1:0]     InData = '0;
    logic              InReady, OutValid;
    logic [DW-1:0]     OutData;
    logic              RamWEnc, RamREnc;
    logic [AW-1:0]     RamWAddr, RamRAddr;
    logic [DW-1:0]     RamWData, RamRData;
    logic              Full, Empty;
    logic [CNT_W-1:0]  Count;
`ifdef SYNC_FIFO_CTRL_FLUSH_EN
    logic              Flush = 1'b0;
`endif

    always #5 Clk = ~Clk;

    sync_fifo_ctrl #(.DataWidth(DW), .Deepth(DEPTH)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .InValid  (InValid),
        .InReady  (InReady),
        .InData   (InData),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutData  (OutData),
`ifdef SYNC_FIFO_CTRL_FLUSH_EN
        .Flush    (Flush),
`endif
        .RamWEnc  (RamWEnc),
        .RamWAddr (RamWAddr),
        .RamWData (RamWData),
        .RamREnc  (RamREnc),
        .RamRAddr (RamRAddr),
        .RamRData (RamRData),
        .Full     (Full),
        .Empty    (Empty),
        .Count    (Count)
    );

    // Behavioural dual-port RAM with a registered read port.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge Clk) begin
        if (RamWEnc) mem[RamWAddr] <= RamWData;
        if (RamREnc) RamRData <= mem[RamRAddr];
    end

    logic [DW-1:0] model[$];
    int            testCount = 0;
    int            failCount = 0;
    int            ramWr, ramRd, acceptTotal, popTotal;
    bit            inflight, randData;
    logic [DW-1:0] nextData, lastPop;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        model.delete();
        ramWr    = 0;
        ramRd    = 0;
        inflight = 1'b0;
    endtask

    task automatic setInputs(input bit valid, input bit ready);
        InValid  = valid;
        InData   = nextData;
        OutReady = ready;
        #1;
    endtask

    task automatic stepCycle();
        bit acc, pp, flushing;
        int unread, skidOcc;
        flushing = 1'b0;
`ifdef SYNC_FIFO_CTRL_FLUSH_EN
        flushing = Flush;
`endif
        acc = InValid && InReady;
        pp  = OutValid && OutReady;
        if (Rst) begin
            unread  = ramWr - ramRd;
            skidOcc = model.size() - unread - int'(inflight);
            if (RamREnc) checkOutput("ren_ram_nonempty", 64'(unread > 0), 64'd1);
            checkOutput("skid_bound", 64'(skidOcc <= 2), 64'd1);
            if (pp) begin
                checkOutput("pop_nonempty", 64'(model.size() > 0), 64'd1);
                if (model.size() > 0) begin
                    lastPop = model.pop_front();
                    checkOutput("out_data", OutData, lastPop);
                end
                popTotal++;
            end
            if (acc) begin
                model.push_back(InData);
                acceptTotal++;
                nextData = randData ? {$urandom(), $urandom()} : nextData + 1;
            end
            ramWr    = ramWr + int'(RamWEnc);
            ramRd    = ramRd + int'(RamREnc);
            inflight = RamREnc;
        end
        @(posedge Clk);
        #1;
        if (flushing) modelReset();
        checkOutput("count", 64'(Count), 64'(model.size()));
        checkOutput("empty", 64'(Empty), 64'(model.size() == 0));
        if (model.size() == DEPTH + 2) checkOutput("full_at_max", 64'(Full), 64'd1);
        if (model.size() < DEPTH) checkOutput("not_full", 64'(Full), 64'd0);
    endtask

    task automatic applyStimulus(input bit valid, input bit ready);
        setInputs(valid, ready);
        stepCycle();
    endtask

    initial begin
        int base, first, last, n;
        modelReset();
        acceptTotal = 0;
        popTotal    = 0;
        randData    = 1'b0;
        nextData    = '0;
        lastPop     = '0;

        // Reset state, with a producer already pushing.
        InValid = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checkOutput("rst_count", 64'(Count), 64'd0);
        checkOutput("rst_empty", 64'(Empty), 64'd1);
        checkOutput("rst_full", 64'(Full), 64'd0);
        checkOutput("rst_outvalid", 64'(OutValid), 64'd0);
        checkOutput("rst_outdata", OutData, 64'd0);
        checkOutput("rst_inready", 64'(InReady), 64'd0);
        checkOutput("rst_wenc", 64'(RamWEnc), 64'd0);
        checkOutput("rst_renc", 64'(RamREnc), 64'd0);
        InValid = 1'b0;
        Rst = 1'b1;

        // 1: single word latency.
        nextData = 64'hA5;
        setInputs(1, 1);
        checkOutput("t1_wenc_c0", 64'(RamWEnc), 64'd1);
        checkOutput("t1_renc_c0", 64'(RamREnc), 64'd0);
        stepCycle();
        setInputs(0, 1);
        checkOutput("t1_renc_c1", 64'(RamREnc), 64'd1);
        stepCycle();
        setInputs(0, 1);
        checkOutput("t1_outvalid_c2", 64'(OutValid), 64'd0);
        stepCycle();
        setInputs(0, 1);
        checkOutput("t1_outvalid_c3", 64'(OutValid), 64'd1);
        checkOutput("t1_outdata_c3", OutData, 64'hA5);
        stepCycle();
        checkOutput("t1_empty_after", 64'(Empty), 64'd1);

        // 2: fill with no consumer, then drain in order.
        nextData = '0;
        base = acceptTotal;
        for (int i = 0; i < 24; i++) applyStimulus(1, 0);
        checkOutput("t2_accepted", 64'(acceptTotal - base), 64'd18);
        checkOutput("t2_count", 64'(Count), 64'd18);
        checkOutput("t2_full", 64'(Full), 64'd1);
        checkOutput("t2_inready", 64'(InReady), 64'd0);
        for (int i = 0; i < 25; i++) applyStimulus(0, 1);
        checkOutput("t2_last", lastPop, 64'd17);
        checkOutput("t2_empty", 64'(Empty), 64'd1);

        // 3: streaming across pointer wrap, no bubbles once flowing.
        base  = popTotal;
        first = -1;
        last  = -1;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1, 1);
            n = popTotal - base;
            if (n >= 1 && first < 0) first = i;
            if (n >= 100) begin
                last = i;
                break;
            end
        end
        checkOutput("t3_reached_100", 64'(last >= 0), 64'd1);
        checkOutput("t3_no_bubbles", 64'(last - first), 64'd99);
        for (int i = 0; i < 25; i++) applyStimulus(0, 1);
        checkOutput("t3_empty", 64'(Empty), 64'd1);

        // 4: full boundary with simultaneous write and pop.
        for (int i = 0; i < 24; i++) applyStimulus(1, 0);
        setInputs(1, 1);
        checkOutput("t4_blocked", 64'(InReady), 64'd0);
        stepCycle();
        setInputs(1, 1);
        checkOutput("t4_reopened", 64'(InReady), 64'd1);
        stepCycle();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1);
            checkOutput("t4_count_const", 64'(Count), 64'd17);
        end
        for (int i = 0; i < 25; i++) applyStimulus(0, 1);

        // 5: random traffic against the queue model.
        randData = 1'b1;
        nextData = {$urandom(), $urandom()};
        base = acceptTotal;
        for (int i = 0; i < 8000 && (acceptTotal - base) < 1000; i++)
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
        checkOutput("t5_accepted", 64'(acceptTotal - base >= 1000), 64'd1);
        for (int i = 0; i < 30; i++) applyStimulus(0, 1);
        checkOutput("t5_empty", 64'(Empty), 64'd1);
        randData = 1'b0;

        // 6: reset mid-operation with a read in flight.
        nextData = 64'd100;
        for (int i = 0; i < 8; i++) applyStimulus(1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0);
        applyStimulus(0, 1);
        checkOutput("t6_count_pre", 64'(Count), 64'd7);
        Rst = 1'b0;
        #1;
        modelReset();
        checkOutput("t6_rst_count", 64'(Count), 64'd0);
        checkOutput("t6_rst_outvalid", 64'(OutValid), 64'd0);
        checkOutput("t6_rst_renc", 64'(RamREnc), 64'd0);
        stepCycle();
        Rst = 1'b1;
        nextData = 64'h3C;
        base = popTotal;
        applyStimulus(1, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1);
        checkOutput("t6_single_pop", 64'(popTotal - base), 64'd1);
        checkOutput("t6_value", lastPop, 64'h3C);

`ifdef SYNC_FIFO_CTRL_FLUSH_EN
        // Flush gives the same outcome as reset.
        nextData = 64'd200;
        for (int i = 0; i < 8; i++) applyStimulus(1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0);
        applyStimulus(0, 1);
        Flush = 1'b1;
        setInputs(1, 1);
        checkOutput("fl_inready", 64'(InReady), 64'd0);
        checkOutput("fl_renc", 64'(RamREnc), 64'd0);
        checkOutput("fl_outvalid", 64'(OutValid), 64'd0);
        stepCycle();
        Flush = 1'b0;
        checkOutput("fl_count", 64'(Count), 64'd0);
        nextData = 64'h3C;
        base = popTotal;
        applyStimulus(1, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1);
        checkOutput("fl_single_pop", 64'(popTotal - base), 64'd1);
        checkOutput("fl_value", lastPop, 64'h3C);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
